// File: rtl/bcd_sevenseg_scan_pkg.sv
// seg7_pkg: segment encodings, digit-slot index and BCD value bundle shared by the scanner.
package seg7_pkg;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  typedef enum logic [1:0] {DIG_ONES, DIG_TENS, DIG_HUNDREDS, DIG_SIGN} dig_t;
  typedef struct packed {
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] o;
    logic       neg;
  } bcd_t;
endpackage

// File: rtl/bcd_sevenseg_scan_if.sv
// bcd_sevenseg_scan_if: BCD load bus in, multiplexed display drive out.
interface bcd_sevenseg_scan_if;
  logic       load;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       neg;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       err;
  logic       frame;
  modport master (output load, hundreds, tens, ones, neg, input an, seg, dp, err, frame);
  modport slave (input load, hundreds, tens, ones, neg, output an, seg, dp, err, frame);
endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: one digit code plus blank/minus controls to active-low gfedcba pattern.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  input  logic       blank,
  input  logic       minus,
  output logic [6:0] seg
);
  logic [6:0] digit;
  always_comb begin
    case (code)
      4'd0: digit = SEG_0;
      4'd1: digit = SEG_1;
      4'd2: digit = SEG_2;
      4'd3: digit = SEG_3;
      4'd4: digit = SEG_4;
      4'd5: digit = SEG_5;
      4'd6: digit = SEG_6;
      4'd7: digit = SEG_7;
      4'd8: digit = SEG_8;
      4'd9: digit = SEG_9;
      default: digit = SEG_E;
    endcase
  end
  // An invalid code must stay visible, so 'E' outranks blanking
  assign seg = minus ? SEG_MINUS : code > 4'd9 ? SEG_E : blank ? SEG_BLANK : digit;
endmodule

// File: rtl/bcd_sevenseg_scan.sv
// bcd_sevenseg_scan: frame-synchronous BCD latch driving a 4-digit multiplexed seven-segment display.
module bcd_sevenseg_scan
  import seg7_pkg::*;
#(
  parameter int REFRESH_CNT = 100000,
  parameter int CNT_W = 17,
  parameter bit BLANK_LEADING = 1'b1
) (
  input logic clk,
  input logic rst,
  bcd_sevenseg_scan_if.slave bus
);
  logic [CNT_W-1:0] cnt;
  dig_t idx;
  bcd_t live, pend, disp;
  logic pend_v, tick, boundary, blank, minus;
  logic [3:0] code;
  logic [6:0] dec_seg;
  assign live = {bus.hundreds, bus.tens, bus.ones, bus.neg};
  assign tick = cnt == CNT_W'(REFRESH_CNT - 1);
  assign boundary = tick && idx == DIG_SIGN;
  assign bus.dp = 1'b1;
  always_comb begin
    code = idx == DIG_ONES ? disp.o : idx == DIG_TENS ? disp.t : idx == DIG_HUNDREDS ? disp.h : 4'd0;
    blank = idx == DIG_TENS ? BLANK_LEADING && disp.h == 4'd0 && disp.t == 4'd0 :
            idx == DIG_HUNDREDS ? BLANK_LEADING && disp.h == 4'd0 :
            idx == DIG_SIGN && !disp.neg;
    minus = idx == DIG_SIGN && disp.neg;
  end
  seg7_decode u_dec (.code(code), .blank(blank), .minus(minus), .seg(dec_seg));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      idx <= DIG_ONES;
      pend <= '0;
      disp <= '0;
      pend_v <= 1'b0;
      bus.an <= 4'hF;
      bus.seg <= SEG_BLANK;
      bus.err <= 1'b0;
      bus.frame <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
      if (tick) idx <= dig_t'(idx + 2'd1);
      bus.frame <= boundary;
      // Commit only at the frame boundary; a load landing on it bypasses the pending regs
      if (boundary) begin
        if (bus.load) disp <= live;
        else if (pend_v) disp <= pend;
        pend_v <= 1'b0;
      end else if (bus.load) begin
        pend <= live;
        pend_v <= 1'b1;
      end
      bus.an <= ~(4'b0001 << idx);
      bus.seg <= dec_seg;
      bus.err <= disp.h > 4'd9 || disp.t > 4'd9 || disp.o > 4'd9;
    end
  end
endmodule
